if_else_stream_driver: RTL



---
 rtl/if_else_stream_driver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/if_else_stream_driver.sv
// Valid/ready front end and FWFT result FIFO around one if/else combine block.
// Optional per-result sequence tags are enabled with `define IF_ELSE_DRV_TAG_EN.
`timescale 1ns/1ps
module if_else_stream_driver #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] array_a_wire_0,
    output logic [31:0] array_b_wire_0,
    input  logic [31:0] temp_combine,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef IF_ELSE_DRV_TAG_EN
    ,
    output logic [7:0]  out_tag
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      wait_cnt_reg;
    logic [31:0]     a_reg, b_reg;
    logic [31:0]     mem_reg [DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            accept, capture, pop;

    // Space is reserved at accept: with one op in flight, a capture can never overflow.
    assign in_ready  = (state_reg == IDLE) && (count_reg < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign capture   = (state_reg == WAIT) && (wait_cnt_reg == 8'(LATENCY - 1));
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state_reg == WAIT);

    assign array_a_wire_0 = a_reg;
    assign array_b_wire_0 = b_reg;
    assign out_data       = mem_reg[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)  state_next = WAIT;
            WAIT:    if (capture) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg        <= in_a;
                b_reg        <= in_b;
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
        end
    end

    // Entries are cleared on reset so out_data reads 0 until the first result lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (capture) begin
                mem_reg[wr_ptr_reg] <= temp_combine;
                wr_ptr_reg          <= wr_ptr_reg + PW'(1);
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({capture, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef IF_ELSE_DRV_TAG_EN
    logic [7:0] tag_cnt_reg, tag_cur_reg;
    logic [7:0] tag_mem_reg [DEPTH];

    assign out_tag = tag_mem_reg[rd_ptr_reg];

    // The tag is latched at accept and travels with the op until its result is pushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_cnt_reg <= '0;
            tag_cur_reg <= '0;
            for (int i = 0; i < DEPTH; i++) tag_mem_reg[i] <= '0;
        end else begin
            if (accept) begin
                tag_cur_reg <= tag_cnt_reg;
                tag_cnt_reg <= tag_cnt_reg + 8'd1;
            end
            if (capture) tag_mem_reg[wr_ptr_reg] <= tag_cur_reg;
        end
    end
`endif

endmodule
